// File: rtl/vec_unit_pipe.sv
// Pipelined LANES-wide signed fixed-point vector unit with saturation and a
// per-lane multi-beat accumulator; fixed STAGES-cycle latency, elastic handshakes.
//
// state    | meaning
// ACC_IDLE | no accumulation open, ACC beat sums from zero
// ACC_RUN  | partial sums held in acc, waiting for the in_last beat
module vec_unit_pipe #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int STAGES     = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_op,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] data_in1,
  input  logic [LANES*DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0]       data_inK,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] data_out,
  output logic [LANES-1:0]            out_sat
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = 2*DW + 1;
  localparam logic signed [WW-1:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_SCALE = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_RELU  = 3'd4;
  localparam logic [2:0] OP_MAX   = 3'd5;
  localparam logic [2:0] OP_MIN   = 3'd6;
  localparam logic [2:0] OP_ACC   = 3'd7;

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;
  acc_state_t state, state_nxt;

  // Returns {sat, value}; everything is evaluated wide enough to be exact before clamping.
  function automatic logic [DW:0] lane_op(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] k,
                                          input logic [DW-1:0] c);
    logic signed [WW-1:0] aw, bw, kw, cw, w;
    aw = WW'(signed'(a));
    bw = WW'(signed'(b));
    kw = WW'(signed'(k));
    cw = WW'(signed'(c));
    case (op)
      OP_ADD:   w = aw + bw;
      OP_SUB:   w = aw - bw;
      OP_SCALE: w = (aw * kw) >>> FRAC_BITS;
      OP_MUL:   w = (aw * bw) >>> FRAC_BITS;
      OP_RELU:  w = aw[WW-1] ? '0 : aw;
      OP_MAX:   w = (aw > bw) ? aw : bw;
      OP_MIN:   w = (aw < bw) ? aw : bw;
      default:  w = cw + aw;
    endcase
    if (w > MAXV) return {1'b1, MAXV[DW-1:0]};
    if (w < MINV) return {1'b1, MINV[DW-1:0]};
    return {1'b0, w[DW-1:0]};
  endfunction

  logic                        adv, accept, is_acc, emit;
  logic [LANES*DW-1:0]         res;
  logic [LANES-1:0]            res_sat;
  logic [DW:0]                 lane_r [LANES];
  logic [DW-1:0]               acc    [LANES];
  logic [LANES-1:0]            sticky;
  logic                        stg_v  [STAGES];
  logic [LANES*DW-1:0]         stg_d  [STAGES];
  logic [LANES-1:0]            stg_s  [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign is_acc   = (in_op == OP_ACC);
  assign emit     = accept && (!is_acc || in_last);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_r[i] = lane_op(in_op, data_in1[i*DW +: DW], data_in2[i*DW +: DW], data_inK,
                               (state == ACC_RUN) ? acc[i] : '0);
    assign res[i*DW +: DW] = lane_r[i][DW-1:0];
    assign res_sat[i]      = lane_r[i][DW] | (is_acc & sticky[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ACC_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept && is_acc) state_nxt = in_last ? ACC_IDLE : ACC_RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      sticky <= '0;
    end else if (accept && is_acc) begin
      for (int i = 0; i < LANES; i++) acc[i] <= in_last ? '0 : res[i*DW +: DW];
      sticky <= in_last ? '0 : res_sat;
    end
  end

  // Non-emitting ACC beats still advance the pipe, entering as bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_v[s] <= 1'b0;
        stg_d[s] <= '0;
        stg_s[s] <= '0;
      end
    end else if (adv) begin
      stg_v[0] <= emit;
      stg_d[0] <= res;
      stg_s[0] <= res_sat;
      for (int s = 1; s < STAGES; s++) begin
        stg_v[s] <= stg_v[s-1];
        stg_d[s] <= stg_d[s-1];
        stg_s[s] <= stg_s[s-1];
      end
    end
  end

  assign out_valid = stg_v[STAGES-1];
  assign data_out  = stg_d[STAGES-1];
  assign out_sat   = stg_s[STAGES-1];

endmodule
